// File: rtl/stat_seq_pipe.sv
// Pipelined synthetic logic cloud: WIDTH-bit words pass through STAGES registered layers of L(x).
// Latency: STAGES cycles from input accept to out_valid, one word per cycle when unstalled.
// Backpressure: global stall, in_ready = !out_valid || out_ready, bubbles are not collapsed.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake, in_data is the input word
//   out_valid/out_ready  output handshake, out_data is the last stage register
//   sig_clr              synchronous clear of sig and txn_count, wins over a same-cycle delivery
//   sig                  running signature: sig = rotl(sig,1) ^ out_data on each delivery
//   txn_count            delivered-word counter, wraps modulo 2^CNT_W
module stat_seq_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             sig_clr,
  output logic [WIDTH-1:0] sig,
  output logic [CNT_W-1:0] txn_count
);

  // One gate layer: c[i] = x[i] ^ (~x[i+1] & x[i+2]) with wrap-around
  // indices, then rotate the result left by one.
  function automatic logic [WIDTH-1:0] layer(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c[i] = x[i] ^ (~x[(i + 1) % WIDTH] & x[(i + 2) % WIDTH]);
    end
    return {c[WIDTH-2:0], c[WIDTH-1]};
  endfunction

  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] v;
  logic              advance;
  logic              deliver;

  // Whole pipeline moves together; only the last stage's occupancy can block it.
  assign advance   = ~v[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign deliver   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= '0;
      end
    end else if (advance) begin
      d[0] <= layer(in_data);
      v[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        d[k] <= layer(d[k-1]);
        v[k] <= v[k-1];
      end
    end
  end

  // Clear takes priority: a delivery in the same cycle still leaves the
  // pipeline but is neither compacted nor counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig       <= '0;
      txn_count <= '0;
    end else if (sig_clr) begin
      sig       <= '0;
      txn_count <= '0;
    end else if (deliver) begin
      sig       <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ out_data;
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stat_seq_pipe.sv
module tb_stat_seq_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance a: WIDTH=8, STAGES=2, CNT_W=16
  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_in_data = '0;
  logic       a_out_valid;
  logic       a_out_ready = 1'b1;
  logic [7:0] a_out_data;
  logic       a_sig_clr = 1'b0;
  logic [7:0] a_sig;
  logic [15:0] a_txn_count;

  // Instance b: WIDTH=5, STAGES=1, CNT_W=4
  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [4:0] b_in_data = '0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic [4:0] b_out_data;
  logic       b_sig_clr = 1'b0;
  logic [4:0] b_sig;
  logic [3:0] b_txn_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stat_seq_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .sig_clr(a_sig_clr), .sig(a_sig), .txn_count(a_txn_count)
  );

  stat_seq_pipe #(.WIDTH(5), .STAGES(1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .sig_clr(b_sig_clr), .sig(b_sig), .txn_count(b_txn_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) tick();
    chk("rst in_ready",  32'(a_in_ready), 32'h1);
    chk("rst out_valid", 32'(a_out_valid), 32'h0);
    chk("rst out_data",  32'(a_out_data), 32'h0);
    chk("rst sig",       32'(a_sig), 32'h0);
    chk("rst txn_count", 32'(a_txn_count), 32'h0);
    rst_n = 1'b1;

    // ---------------- known vectors: 01 -> 44, 00 -> 00, FF -> FF ----------------
    a_in_valid = 1'b1; a_in_data = 8'h01;
    tick();
    chk("kv1 out_valid early", 32'(a_out_valid), 32'h0);
    a_in_data = 8'h00;
    tick();
    chk("kv1 out_valid", 32'(a_out_valid), 32'h1);
    chk("kv1 01->44", 32'(a_out_data), 32'h44);
    a_in_data = 8'hFF;
    tick();
    chk("kv2 00->00", 32'(a_out_data), 32'h00);
    a_in_valid = 1'b0;
    tick();
    chk("kv3 FF->FF", 32'(a_out_data), 32'hFF);
    tick();
    chk("kv drain out_valid", 32'(a_out_valid), 32'h0);
    // sig: 0 -> 44 -> 88 -> rotl(88)^FF = EE
    chk("kv sig", 32'(a_sig), 32'hEE);
    chk("kv txn_count", 32'(a_txn_count), 32'h3);

    // ---------------- signature ----------------
    a_sig_clr = 1'b1;
    tick();
    a_sig_clr = 1'b0;
    chk("clr sig", 32'(a_sig), 32'h0);
    chk("clr txn_count", 32'(a_txn_count), 32'h0);
    a_in_valid = 1'b1; a_in_data = 8'h01;
    tick();
    a_in_data = 8'hFF;
    tick();
    a_in_valid = 1'b0;
    tick();
    chk("sig after 44", 32'(a_sig), 32'h44);
    chk("cnt after 44", 32'(a_txn_count), 32'h1);
    tick();
    chk("sig after FF", 32'(a_sig), 32'h77);
    chk("cnt after FF", 32'(a_txn_count), 32'h2);

    // ---------------- back-pressure ----------------
    a_in_valid = 1'b1; a_in_data = 8'h01;
    tick();
    a_in_data = 8'hFF;
    tick();
    chk("bp first valid", 32'(a_out_valid), 32'h1);
    a_in_data = 8'h00;
    a_out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp in_ready stall", 32'(a_in_ready), 32'h0);
      chk("bp out_data hold", 32'(a_out_data), 32'h44);
      tick();
    end
    chk("bp out_data hold end", 32'(a_out_data), 32'h44);
    a_out_ready = 1'b1;
    #1;
    chk("bp in_ready release", 32'(a_in_ready), 32'h1);
    tick();
    a_in_valid = 1'b0;
    chk("bp order 2", 32'(a_out_data), 32'hFF);
    chk("bp valid 2", 32'(a_out_valid), 32'h1);
    tick();
    chk("bp order 3", 32'(a_out_data), 32'h00);
    chk("bp valid 3", 32'(a_out_valid), 32'h1);
    tick();
    chk("bp drained", 32'(a_out_valid), 32'h0);
    chk("bp cnt", 32'(a_txn_count), 32'h5);

    // ---------------- bubbles ----------------
    for (int i = 0; i < 6; i++) begin
      a_in_valid = (i % 2 == 0) && (i < 4);
      a_in_data = (i == 0) ? 8'h01 : 8'hFF;
      tick();
      // out_valid after this edge reflects in_valid from the previous cycle
      if (i >= 1) chk("bubble out_valid", 32'(a_out_valid), (i == 1 || i == 3) ? 32'h1 : 32'h0);
    end

    // ---------------- sig_clr vs delivery priority ----------------
    a_in_valid = 1'b1; a_in_data = 8'h01;
    tick();
    a_in_valid = 1'b0;
    tick();
    chk("prio pending", 32'(a_out_valid), 32'h1);
    a_sig_clr = 1'b1;
    tick();
    a_sig_clr = 1'b0;
    chk("prio sig", 32'(a_sig), 32'h0);
    chk("prio cnt", 32'(a_txn_count), 32'h0);
    chk("prio delivered", 32'(a_out_valid), 32'h0);

    // ---------------- reset mid-stream ----------------
    a_in_valid = 1'b1; a_in_data = 8'h01;
    tick();
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(a_out_valid), 32'h0);
    chk("midrst in_ready", 32'(a_in_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst no output", 32'(a_out_valid), 32'h0);
    end

    // ---------------- WIDTH=5, STAGES=1, CNT_W=4 ----------------
    b_in_valid = 1'b1; b_in_data = 5'h01;
    tick();
    chk("w5 01->12", 32'(b_out_data), 32'h12);
    chk("w5 valid", 32'(b_out_valid), 32'h1);
    for (int i = 1; i < 17; i++) tick();
    b_in_valid = 1'b0;
    tick();
    chk("w5 drained", 32'(b_out_valid), 32'h0);
    chk("wrap cnt", 32'(b_txn_count), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
